// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: ID-side operands/control in, EX-side ALU inputs and control out.
// The writeback snoop signals are only consumed when ID_EX_WB_BYPASS_EN is defined.
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7_5;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            wb_we;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            ex_valid;
    logic [XLEN-1:0] ex_ina;
    logic [XLEN-1:0] ex_inb;
    logic [3:0]      ex_aluop;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_illegal;

    modport master (
        output id_valid, stall, flush, id_pc, id_opcode, id_funct3, id_funct7_5,
               id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               wb_we, wb_rd, wb_data,
        input  ex_valid, ex_ina, ex_inb, ex_aluop, ex_store_data, ex_rd, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
    );

    modport slave (
        input  id_valid, stall, flush, id_pc, id_opcode, id_funct3, id_funct7_5,
               id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               wb_we, wb_rd, wb_data,
        output ex_valid, ex_ina, ex_inb, ex_aluop, ex_store_data, ex_rd, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU opcode and operand sources, then registers them for EX.
// Optional macro ID_EX_WB_BYPASS_EN forwards same-cycle writeback data into rs1/rs2 at load.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [XLEN-1:0] SHAMT_MASK = XLEN'(5'h1F);

    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic f7_5);
        logic [3:0] code;
        case (f3)
            3'b000:  code = f7_5 ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_ina;
    logic [XLEN-1:0] w_inb;
    logic [3:0]      w_aluop;
    logic            w_shift;
    logic            w_reg_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_branch;
    logic            w_jump;
    logic            w_illegal;
    logic            w_bubble;

`ifdef ID_EX_WB_BYPASS_EN
    assign w_rs1_val = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1))
                       ? bus.wb_data : bus.id_rs1_data;
    assign w_rs2_val = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2))
                       ? bus.wb_data : bus.id_rs2_data;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data, bus.id_rs1, bus.id_rs2};
    assign w_rs1_val   = bus.id_rs1_data;
    assign w_rs2_val   = bus.id_rs2_data;
`endif

    always_comb begin
        w_ina       = w_rs1_val;
        w_inb       = w_rs2_val;
        w_aluop     = ALU_ADD;
        w_shift     = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        case (bus.id_opcode)
            OP_R: begin
                w_aluop     = f_alu(bus.id_funct3, bus.id_funct7_5);
                w_shift     = (bus.id_funct3 == 3'b001) || (bus.id_funct3 == 3'b101);
                w_reg_write = 1'b1;
            end
            OP_I: begin
                // addi has no subtract form, so funct7_5 (an imm bit) is ignored there
                w_inb       = bus.id_imm;
                w_aluop     = (bus.id_funct3 == 3'b000) ? ALU_ADD
                                                        : f_alu(bus.id_funct3, bus.id_funct7_5);
                w_shift     = (bus.id_funct3 == 3'b001) || (bus.id_funct3 == 3'b101);
                w_reg_write = 1'b1;
            end
            OP_LOAD: begin
                w_inb       = bus.id_imm;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            OP_STORE: begin
                w_inb       = bus.id_imm;
                w_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                w_aluop  = ALU_SUB;
                w_branch = 1'b1;
            end
            OP_LUI: begin
                w_ina       = '0;
                w_inb       = bus.id_imm;
                w_reg_write = 1'b1;
            end
            OP_AUIPC: begin
                w_ina       = bus.id_pc;
                w_inb       = bus.id_imm;
                w_reg_write = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                w_ina       = bus.id_pc;
                w_inb       = XLEN'(4);
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Only shamt survives so the ALU never sees an out-of-range shift amount
        if (w_shift) w_inb = w_inb & SHAMT_MASK;
        if (bus.id_rd == '0) w_reg_write = 1'b0;
    end

    assign w_bubble = bus.flush || (!bus.stall && !bus.id_valid);

    logic            r_valid;
    logic [XLEN-1:0] r_ina;
    logic [XLEN-1:0] r_inb;
    logic [3:0]      r_aluop;
    logic [XLEN-1:0] r_store_data;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_pc;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_branch;
    logic            r_jump;
    logic            r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ina        <= '0;
            r_inb        <= '0;
            r_aluop      <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_pc         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_bubble) begin
            // Bubble kills side effects only; datapath fields keep their last value
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!bus.stall) begin
            r_valid      <= 1'b1;
            r_ina        <= w_ina;
            r_inb        <= w_inb;
            r_aluop      <= w_aluop;
            r_store_data <= w_rs2_val;
            r_rd         <= bus.id_rd;
            r_pc         <= bus.id_pc;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_branch     <= w_branch;
            r_jump       <= w_jump;
            r_illegal    <= w_illegal;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_ina        = r_ina;
    assign bus.ex_inb        = r_inb;
    assign bus.ex_aluop      = r_aluop;
    assign bus.ex_store_data = r_store_data;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.ex_branch     = r_branch;
    assign bus.ex_jump       = r_jump;
    assign bus.ex_illegal    = r_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized stream
// compared against an instruction-level reference model.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    id_ex_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] ina;
        logic [31:0] inb;
        logic [3:0]  aluop;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        il;
    } exp_t;

    exp_t exp_q;

    // ALU code by funct3 for the "base" (funct7_5=0) form of each operation
    logic [3:0] base_code [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0111,
                                  4'b0011, 4'b0101, 4'b0001, 4'b0000};

    function automatic logic [3:0] op_code(input logic [2:0] f3, input logic alt);
        if (alt && f3 == 3'd0) return 4'b0110;
        if (alt && f3 == 3'd5) return 4'b1001;
        return base_code[f3];
    endfunction

    function automatic exp_t model_load();
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        a  = bus.id_rs1_data;
        b  = bus.id_rs2_data;
        f3 = bus.id_funct3;
`ifdef ID_EX_WB_BYPASS_EN
        if (bus.wb_we && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs1) a = bus.wb_data;
        if (bus.wb_we && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs2) b = bus.wb_data;
`endif
        e       = '0;
        e.valid = 1'b1;
        e.pc    = bus.id_pc;
        e.rd    = bus.id_rd;
        e.sd    = b;
        e.aluop = 4'b0010;
        e.ina   = a;
        e.inb   = b;
        case (bus.id_opcode)
            7'h33: begin
                e.aluop = op_code(f3, bus.id_funct7_5);
                e.rw    = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) e.inb = b % 32;
            end
            7'h13: begin
                e.aluop = op_code(f3, bus.id_funct7_5 && f3 == 3'd5);
                e.rw    = 1'b1;
                e.inb   = (f3 == 3'd1 || f3 == 3'd5) ? bus.id_imm % 32 : bus.id_imm;
            end
            7'h03: begin e.inb = bus.id_imm; e.mr = 1'b1; e.rw = 1'b1; end
            7'h23: begin e.inb = bus.id_imm; e.mw = 1'b1; end
            7'h63: begin e.aluop = 4'b0110; e.br = 1'b1; end
            7'h37: begin e.ina = 0; e.inb = bus.id_imm; e.rw = 1'b1; end
            7'h17: begin e.ina = bus.id_pc; e.inb = bus.id_imm; e.rw = 1'b1; end
            7'h6F, 7'h67: begin e.ina = bus.id_pc; e.inb = 4; e.jp = 1'b1; e.rw = 1'b1; end
            default: e.il = 1'b1;
        endcase
        if (bus.id_rd == 0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.valid = bus.ex_valid;
        o.ina   = bus.ex_ina;
        o.inb   = bus.ex_inb;
        o.aluop = bus.ex_aluop;
        o.sd    = bus.ex_store_data;
        o.rd    = bus.ex_rd;
        o.pc    = bus.ex_pc;
        o.rw    = bus.ex_reg_write;
        o.mr    = bus.ex_mem_read;
        o.mw    = bus.ex_mem_write;
        o.br    = bus.ex_branch;
        o.jp    = bus.ex_jump;
        o.il    = bus.ex_illegal;
        return o;
    endfunction

    // Advance one clock and move the model to the state the inputs ask for
    task automatic step();
        exp_t nxt;
        nxt = exp_q;
        if (bus.flush || (!bus.stall && !bus.id_valid)) begin
            nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0;
            nxt.br = 0; nxt.jp = 0; nxt.il = 0;
        end else if (!bus.stall) begin
            nxt = model_load();
        end
        @(posedge clk);
        #1;
        exp_q = nxt;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [31:0] pc);
        bus.id_opcode   = op;
        bus.id_funct3   = f3;
        bus.id_funct7_5 = f7;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_pc       = pc;
    endtask

    task automatic test_reset();
        exp_t o;
        o = observe();
        checks++;
        if (o !== 144'd0) begin
            errors++; $display("FAIL reset_init: got %h want 0", o);
        end
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 32'h40);
        step();
        checks++;
        if (bus.ex_ina !== 32'd5) begin
            errors++; $display("FAIL reset_preload_ina: got %h want 5", bus.ex_ina);
        end
        #2 reset = 1'b1;
        #1;
        exp_q = '0;
        o = observe();
        checks++;
        if (o !== 144'd0) begin
            errors++; $display("FAIL reset_async: got %h want 0", o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        checks++;
        if (bus.ex_ina !== 32'd5 || bus.ex_inb !== 32'd7 || bus.ex_aluop !== 4'b0010) begin
            errors++;
            $display("FAIL reset_reload: got ina=%h inb=%h op=%b want 5 7 0010",
                     bus.ex_ina, bus.ex_inb, bus.ex_aluop);
        end
    endtask

    task automatic test_decode();
        set_instr(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 32'h80);
        step();
        checks++;
        if (bus.ex_aluop !== 4'b0110) begin
            errors++; $display("FAIL dec_sub: got %b want 0110", bus.ex_aluop);
        end
        set_instr(7'h13, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'hFFFFFFFD, 32'h84);
        step();
        checks++;
        if (bus.ex_aluop !== 4'b0010 || bus.ex_inb !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL dec_addi: got op=%b inb=%h want 0010 fffffffd",
                               bus.ex_aluop, bus.ex_inb);
        end
        set_instr(7'h13, 3'd5, 1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'h40000405, 32'h88);
        step();
        checks++;
        if (bus.ex_aluop !== 4'b1001 || bus.ex_inb !== 32'd5) begin
            errors++; $display("FAIL dec_srai: got op=%b inb=%h want 1001 5",
                               bus.ex_aluop, bus.ex_inb);
        end
        set_instr(7'h33, 3'd1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'hFFFFFFE3, 32'd0, 32'h8C);
        step();
        checks++;
        if (bus.ex_aluop !== 4'b0100 || bus.ex_inb !== 32'd3) begin
            errors++; $display("FAIL dec_sll: got op=%b inb=%h want 0100 3",
                               bus.ex_aluop, bus.ex_inb);
        end
    endtask

    task automatic test_stall_flush();
        set_instr(7'h03, 3'd2, 1'b0, 5'd1, 5'd2, 5'd6, 32'h1000, 32'h55, 32'd8, 32'h90);
        step();
        checks++;
        if (bus.ex_inb !== 32'd8 || bus.ex_mem_read !== 1'b1 || bus.ex_valid !== 1'b1) begin
            errors++; $display("FAIL lw_load: got inb=%h mr=%b v=%b want 8 1 1",
                               bus.ex_inb, bus.ex_mem_read, bus.ex_valid);
        end
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_instr(7'h33, 3'($urandom), 1'($urandom), 5'd7, 5'd8, 5'd9,
                      $urandom, $urandom, $urandom, $urandom);
            step();
            checks++;
            if (observe() !== exp_q || bus.ex_inb !== 32'd8) begin
                errors++; $display("FAIL stall_hold%0d: got %h want %h", k, observe(), exp_q);
            end
        end
        bus.flush = 1'b1;
        step();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_inb !== 32'd8) begin
            errors++; $display("FAIL stall_flush: got v=%b mr=%b inb=%h want 0 0 8",
                               bus.ex_valid, bus.ex_mem_read, bus.ex_inb);
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_special();
        set_instr(7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd3, 32'd3, 32'h20, 32'h100);
        step();
        checks++;
        if (bus.ex_ina !== 32'h100 || bus.ex_inb !== 32'd4 || bus.ex_jump !== 1'b1
            || bus.ex_reg_write !== 1'b1) begin
            errors++; $display("FAIL jal: got ina=%h inb=%h jp=%b rw=%b want 100 4 1 1",
                               bus.ex_ina, bus.ex_inb, bus.ex_jump, bus.ex_reg_write);
        end
        set_instr(7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd2, 32'hDEAD, 32'd3, 32'h12345000, 32'h104);
        step();
        checks++;
        if (bus.ex_ina !== 32'd0 || bus.ex_inb !== 32'h12345000) begin
            errors++; $display("FAIL lui: got ina=%h inb=%h want 0 12345000",
                               bus.ex_ina, bus.ex_inb);
        end
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd0, 32'h108);
        step();
        checks++;
        if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b1) begin
            errors++; $display("FAIL add_rd0: got rw=%b v=%b want 0 1",
                               bus.ex_reg_write, bus.ex_valid);
        end
        set_instr(7'h00, 3'd0, 1'b0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 32'h10C);
        step();
        checks++;
        if (bus.ex_illegal !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_aluop !== 4'b0010
            || {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch,
                bus.ex_jump} !== 5'b0) begin
            errors++; $display("FAIL illegal: got il=%b v=%b op=%b ctl=%b want 1 1 0010 00000",
                               bus.ex_illegal, bus.ex_valid, bus.ex_aluop,
                               {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                bus.ex_branch, bus.ex_jump});
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want_hit;
`ifdef ID_EX_WB_BYPASS_EN
        want_hit = 32'hAA;
`else
        want_hit = 32'h11;
`endif
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd3;
        bus.wb_data = 32'hAA;
        set_instr(7'h23, 3'd2, 1'b0, 5'd4, 5'd3, 5'd0, 32'h1000, 32'h11, 32'd4, 32'h200);
        step();
        checks++;
        if (bus.ex_store_data !== want_hit || bus.ex_mem_write !== 1'b1) begin
            errors++; $display("FAIL bypass_hit: got sd=%h mw=%b want %h 1",
                               bus.ex_store_data, bus.ex_mem_write, want_hit);
        end
        bus.wb_rd = 5'd0;
        set_instr(7'h23, 3'd2, 1'b0, 5'd4, 5'd3, 5'd0, 32'h1000, 32'h11, 32'd4, 32'h204);
        step();
        checks++;
        if (bus.ex_store_data !== 32'h11) begin
            errors++; $display("FAIL bypass_rd0: got sd=%h want 11", bus.ex_store_data);
        end
        bus.wb_we = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        exp_t       o;
        for (int i = 0; i < 400; i++) begin
            set_instr(($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 10],
                      3'($urandom), 1'($urandom), 5'($urandom % 4), 5'($urandom % 4),
                      5'($urandom % 4), $urandom, $urandom, $urandom, $urandom);
            bus.stall    = ($urandom % 5 == 0);
            bus.flush    = ($urandom % 10 == 0);
            bus.id_valid = ($urandom % 8 != 0);
            bus.wb_we    = 1'($urandom);
            bus.wb_rd    = 5'($urandom % 4);
            bus.wb_data  = $urandom;
            step();
            o = observe();
            checks++;
            if (o !== exp_q) begin
                errors++; $display("FAIL random_%0d: got %h want %h", i, o, exp_q);
            end
        end
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.id_valid = 1'b1;
        bus.wb_we    = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.id_valid = 1'b1;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        set_instr(7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        exp_q = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        test_reset();
        test_decode();
        test_stall_flush();
        test_special();
        test_bypass();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Captures decoded operands and control at the clock edge.
- Generates the registered 4-bit ALU opcode from opcode/funct3/funct7[5], and performs operand-B and operand-A source selection.
- Drives the ALU inputs (ex_ina, ex_inb, ex_aluop) and carries store data, rd and control bits to the later stages.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- stall  in  1  hold all outputs this cycle.
- flush  in  1  load a bubble this cycle.
- id_pc  in  XLEN  instruction PC.
- id_opcode  in  7  instr[6:0].
- id_funct3  in  3  instr[14:12].
- id_funct7_5  in  1  instr[30].
- id_rs1, id_rs2  in  RA_W each  source register addresses.
- id_rd  in  RA_W  destination register.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  sign-extended immediate (format already selected).
- wb_we  in  1  writeback write enable (used only with the optional feature).
- wb_rd  in  RA_W  writeback destination (optional feature).
- wb_data  in  XLEN  writeback data (optional feature).
- ex_valid  out  1  EX slot valid.
- ex_ina, ex_inb  out  XLEN each  ALU operands.
- ex_aluop  out  4  ALU operation.
- ex_store_data  out  XLEN  rs2 value for stores.
- ex_rd  out  RA_W  destination register.
- ex_pc  out  XLEN  PC.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  control.
- ex_illegal  out  1  unknown opcode.

Behaviour:
- Reset is asynchronous: every output goes to 0 immediately.
- Update priority at each rising edge: reset > flush > stall > load.
- flush:
  - Clears ex_valid, all five control outputs and ex_illegal.
  - Datapath fields (ina, inb, aluop, store_data, rd, pc) hold their values.
  - flush with stall asserted: flush wins.
- stall (without flush): every output holds; inputs are ignored.
- load: all outputs take their decoded values from the current inputs. Latency is 1 cycle.
- id_valid=0 on load: same effect as flush.
- ALU opcode encoding: add 0010, sub 0110, and 0000, or 0001, xor 0011, srl 0101, sll 0100, sra 1001, sltu 0111, slt 1000.
- Decode for R-type (0110011); ina=rs1, inb=rs2, reg_write=1:
  - funct3 000: sub if funct7_5 else add.
  - 001 sll; 010 slt; 011 sltu; 100 xor; 110 or; 111 and.
  - 101: sra if funct7_5 else srl.
- I-ALU (0010011): same table as R-type with inb=imm and reg_write=1. Exceptions:
  - funct3 000 is always add (funct7_5 ignored).
  - funct3 101 uses funct7_5 to select srai/srli.
- Load (0000011): add, inb=imm, mem_read=1, reg_write=1.
- Store (0100011): add, inb=imm, mem_write=1, store_data=rs2.
- Branch (1100011): sub, ina=rs1, inb=rs2, branch=1.
- LUI (0110111): ina=0, inb=imm, add, reg_write=1.
- AUIPC (0010111): ina=pc, inb=imm, add, reg_write=1.
- JAL (1101111) / JALR (1100111): ina=pc, inb=4, add (link value), jump=1, reg_write=1.
- Any other opcode:
  - ex_illegal=1, ex_valid=1, aluop=add.
  - All five control outputs 0.
- Shift ops (sll/srl/sra, register or immediate form): ex_inb = {27'b0, source[4:0]}. Upper bits are masked so the ALU's full-width shift stays legal.
- reg_write is forced to 0 whenever id_rd==0.
- ex_store_data always carries the rs2 value, including for non-store instructions.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: at load, if wb_we=1, wb_rd!=0 and wb_rd==id_rs1, wb_data replaces id_rs1_data in every use. The same rule applies independently to rs2, covering inb and store_data.
- Not defined: wb_* inputs are ignored and register-file data is used unmodified.

Test Plan:
- Reset mid-operation: load `add` (rs1_data=5, rs2_data=7), then assert reset between edges. Required: all outputs 0 immediately; after release and one load, ex_ina=5, ex_inb=7, ex_aluop=0010.
- R/I decode sweep:
  - sub (funct7_5=1, funct3 000) -> aluop 0110.
  - addi with imm=-3, funct7_5=1 -> aluop 0010, inb=0xFFFFFFFD.
  - srai with imm=0x40000405 -> aluop 1001, inb=5.
  - sll with rs2_data=0xFFFFFFE3 -> inb=3.
- Stall then flush:
  - Load lw (imm=8), stall 2 cycles: outputs unchanged.
  - Then stall+flush: ex_valid=0, mem_read=0, ex_inb still 8.
- Special opcodes:
  - jal at pc=0x100 -> ina=0x100, inb=4, jump=1.
  - lui imm=0x12345000 -> ina=0, inb=0x12345000.
  - add with rd=0 -> reg_write=0.
  - opcode 0000000 -> ex_illegal=1, all control outputs 0.
- With ID_EX_WB_BYPASS_EN: wb_we=1, wb_rd=3, wb_data=0xAA; sw with rs2=3, rs2_data=0x11 -> store_data=0xAA. Repeat with wb_rd=0 -> store_data=0x11. Without the macro: store_data=0x11 in both cases.
